// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start, LSB-first data, optional parity, 1-2 stops.
// Outputs are registered from the next state so they change on the accepting edge.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic                  final_stop;
    logic                  accept;
    logic                  par_bit;
    logic                  tx_n;
    logic                  busy_n;

    assign final_stop = (state_q == S_STOP2) ||
                        ((state_q == S_STOP1) && !stop2_q);
    assign accept     = DATA_VALID && ((state_q == S_IDLE) || final_stop);
    assign par_bit    = (^data_q) ^ par_typ_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_n = S_START;
            end
            S_START: begin
                state_n = S_DATA;
                cnt_n   = '0;
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    state_n = par_en_q ? S_PARITY : S_STOP1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_n = S_STOP1;
            end
            S_STOP1: begin
                if (stop2_q)     state_n = S_STOP2;
                else if (accept) state_n = S_START;
                else             state_n = S_IDLE;
            end
            S_STOP2: begin
                state_n = accept ? S_START : S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Line value for the cycle that begins at this edge.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != S_IDLE);
        unique case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_q[cnt_n];
            S_PARITY: tx_n = par_bit;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            TX_OUT  <= tx_n;
            BUSY    <= busy_n;
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                stop2_q   <= STOP2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen: frame-level model feeds an expected
// per-cycle line queue that a negedge monitor drains and compares.
module tb_uart_tx_frame_gen;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic          TX_OUT;
    logic          BUSY;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic seen[$];

    uart_tx_frame_gen #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Whole frame as the sequence of line levels, one entry per bit time.
    function automatic void push_frame(input logic [DW-1:0] d, input logic pe,
                                       input logic pt, input logic s2);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    // A request is taken only when the previous frame has fully drained.
    always @(posedge CLK) begin
        if (RST && DATA_VALID && exp_q.size() == 0)
            push_frame(P_DATA, PAR_EN, PAR_TYP, STOP2);
    end

    always @(negedge RST) exp_q.delete();

    always @(negedge CLK) begin
        logic et;
        logic eb;
        if (exp_q.size() > 0) begin
            et = exp_q.pop_front();
            eb = 1'b1;
        end else begin
            et = 1'b1;
            eb = 1'b0;
        end
        checks++;
        if (TX_OUT !== et || BUSY !== eb) begin
            failures++;
            $display("FAIL line t=%0t tx=%b busy=%b expected tx=%b busy=%b",
                     $time, TX_OUT, BUSY, et, eb);
        end
        if (BUSY === 1'b1) seen.push_back(TX_OUT);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pe,
                        input logic pt, input logic s2);
        int n = 0;
        while (exp_q.size() > 1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got busy=%b required idle", BUSY);
        end
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got queue=%0d required 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    // pat holds the first transmitted bit at position n-1.
    task automatic check_seen(input string nm, input logic [31:0] pat, input int n);
        logic [31:0] act;
        checks++;
        if (seen.size() != n) begin
            failures++;
            $display("FAIL %s_len got %0d bits required %0d", nm, seen.size(), n);
        end else begin
            act = '0;
            foreach (seen[i]) act = {act[30:0], seen[i]};
            checks++;
            if (act != pat) begin
                failures++;
                $display("FAIL %s got %b required %b", nm, act, pat);
            end
        end
        seen.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end

    initial begin
        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        repeat (3) tick();
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got tx=%b busy=%b required 1 0", TX_OUT, BUSY);
        end
        RST = 1'b1;
        tick();
        seen.delete();

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_idle();
        check_seen("even_a5", 32'b01010010101, 11);

        send(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check_seen("odd_a5", 32'b01010010111, 11);

        send(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_seen("stop2_3c", 32'b00011110011, 11);

        send(8'h55, 1'b0, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check_seen("b2b", 32'b01010101010111100001, 20);

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        P_DATA     = 8'hFF;
        PAR_TYP    = 1'b1;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        wait_idle();
        check_seen("integrity", 32'b01010010101, 11);

        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got tx=%b busy=%b required 1 0", TX_OUT, BUSY);
        end
        tick();
        tick();
        RST = 1'b1;
        seen.delete();
        send(8'h81, 1'b0, 1'b0, 1'b0);
        wait_idle();
        check_seen("after_reset_81", 32'b0100000011, 10);

        for (int c = 0; c < 600; c++) begin
            DATA_VALID = ($urandom_range(0, 3) == 0);
            P_DATA     = DW'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            STOP2      = 1'($urandom);
            tick();
        end
        DATA_VALID = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
